mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3: bit width of the count.
REQ-002 Parameter MODULUS, default 8: number of count states. Legal range 2..2**WIDTH; out-of-range is an elaboration error.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 en  input  1: count enable.
REQ-006 up_dn  input  1: direction select; 1 = up, 0 = down.
REQ-007 load  input  1: synchronous parallel load request.
REQ-008 load_val  input  WIDTH: value to load.
REQ-009 count  output  WIDTH: registered binary count.
REQ-010 count_gray  output  WIDTH: Gray-coded count, combinational from count.
REQ-011 tc  output  1: terminal count, combinational.
REQ-012 wrap  output  1: registered one-cycle pulse marking a completed wrap.

Function
REQ-013 count SHALL always hold a value in 0..MODULUS-1.
REQ-014 Per-edge priority SHALL be rst > load > en; with none of these asserted, count holds.
REQ-015 load=1: count <= load_val when load_val < MODULUS, else count <= MODULUS-1. en and up_dn are ignored that cycle.
REQ-016 en=1, up_dn=1, no load: count <= count+1, except MODULUS-1 -> 0.
REQ-017 en=1, up_dn=0, no load: count <= count-1, except 0 -> MODULUS-1.
REQ-018 Next-count arithmetic SHALL be carried out in WIDTH+1 bits, so MODULUS=2**WIDTH wraps correctly without overflow aliasing.
REQ-019 tc SHALL be en & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
REQ-020 wrap SHALL be 1 in the cycle after any edge where tc=1, load=0 and rst=0; otherwise wrap=0.
REQ-021 A load that coincides with tc=1 SHALL NOT set wrap.
REQ-022 count_gray SHALL equal count ^ (count >> 1).
REQ-023 A change of up_dn takes effect at the next edge; there is no turnaround cycle.
REQ-024 Holding en=0 SHALL freeze count and keep wrap=0.

Reset
REQ-025 rst=1 at an edge SHALL set count=0 and wrap=0, overriding load and en.
REQ-026 Asserting rst mid-count SHALL discard the in-progress sequence; counting resumes from 0 on the first edge after rst deasserts with en=1.
REQ-027 During rst, tc SHALL follow REQ-019, using the reset value of count.

Verification (WIDTH=3, MODULUS=6 unless noted)
REQ-028 Reset, then en=1, up_dn=1 for 8 cycles -> count 1,2,3,4,5,0,1,2; tc=1 while count=5; wrap=1 only in the cycle where count=0 after 5.
REQ-029 From count=2, en=1, up_dn=0 for 4 cycles -> count 1,0,5,4; tc=1 at count=0; wrap pulse coincides with count=5.
REQ-030 load=1, load_val=7 -> count=5 (clamped). Then load_val=3 with en=1, up_dn=1 -> count=3 (load wins). Load during tc=1 -> wrap stays 0.
REQ-031 count=4 running up; rst=1 together with load=1, load_val=2 -> count=0, wrap=0. rst released, en=1 -> count 1.
REQ-032 WIDTH=4, MODULUS=16, up from 14 -> count 15,0 with wrap pulse; count_gray sequence 0x9,0x8,0x0.
REQ-033 en=0 for 5 cycles at count=3 with up_dn toggling -> count stays 3, tc=0, wrap=0.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter with synchronous load, Gray-coded view,
// terminal-count flag and a registered wrap pulse.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset (count=0, wrap=0)
//   en         - count enable
//   up_dn      - direction: 1 = up, 0 = down
//   load       - synchronous parallel load (has priority over en)
//   load_val   - value to load, clamped to MODULUS-1
//   count      - registered binary count, always in 0..MODULUS-1
//   count_gray - Gray-coded view of count (combinational)
//   tc         - terminal count: the enabled step about to happen wraps (combinational)
//   wrap       - registered one-cycle pulse after a completed wrap
module mod_updown_counter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS = 2**WIDTH is representable and compares cleanly.
  localparam int unsigned CW = WIDTH + 1;

  localparam logic [CW-1:0] MOD_EXT    = CW'(MODULUS);
  localparam logic [CW-1:0] MOD_M1_EXT = CW'(MODULUS - 1);

  // Reject illegal moduli at elaboration.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_updown_counter: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [CW-1:0]    count_ext;
  logic [CW-1:0]    load_ext;
  logic             at_top;
  logic             at_bottom;

  assign count_ext = {1'b0, count_q};
  assign load_ext  = {1'b0, load_val};
  assign at_top    = (count_ext == MOD_M1_EXT);
  assign at_bottom = (count_q == '0);

  // Terminal count: the enabled step in the current direction wraps.
  assign tc = en & ((up_dn & at_top) | (~up_dn & at_bottom));

  // Next-state: load beats count enable; nothing asserted holds.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      if (load_ext < MOD_EXT) begin
        count_d = load_val;
      end else begin
        count_d = WIDTH'(MOD_M1_EXT);
      end
    end else if (en) begin
      wrap_d = tc;
      if (up_dn) begin
        count_d = at_top ? '0 : WIDTH'(count_ext + CW'(1));
      end else begin
        count_d = at_bottom ? WIDTH'(MOD_M1_EXT) : WIDTH'(count_ext - CW'(1));
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign count_gray = count_q ^ (count_q >> 1);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: DUT A (WIDTH=3, MODULUS=6) and DUT B
// (WIDTH=4, MODULUS=16) checked every cycle against an arithmetic model,
// plus directed vectors with literal expected values.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_up, a_load;
  logic [2:0] a_lv, a_cnt, a_gray;
  logic       a_tc, a_wrap;

  logic       b_rst, b_en, b_up, b_load;
  logic [3:0] b_lv, b_cnt, b_gray;
  logic       b_tc, b_wrap;

  mod_updown_counter #(.WIDTH(3), .MODULUS(6)) u_dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .count(a_cnt), .count_gray(a_gray), .tc(a_tc), .wrap(a_wrap)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .count(b_cnt), .count_gray(b_gray), .tc(b_tc), .wrap(b_wrap)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  int ma_cnt = 0;
  int mb_cnt = 0;
  bit ma_wrap = 1'b0;
  bit mb_wrap = 1'b0;

  // Model: next count from plain modular arithmetic.
  function automatic int m_next(int c, int m, bit rst, bit ld, int lv, bit en, bit up);
    if (rst) return 0;
    if (ld) return (lv < m) ? lv : m - 1;
    if (!en) return c;
    return up ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  // Model: terminal count means the enabled step leaves the 0..m-1 range.
  function automatic bit m_tc(int c, int m, bit en, bit up);
    return en && (up ? (c + 1 >= m) : (c - 1 < 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    nvec++;
    if (act !== 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the clock edge from the inputs applied for that edge.
  always @(posedge clk) begin
    ma_wrap = !a_rst && !a_load && m_tc(ma_cnt, 6, a_en, a_up);
    ma_cnt  = m_next(ma_cnt, 6, a_rst, a_load, int'(a_lv), a_en, a_up);
    mb_wrap = !b_rst && !b_load && m_tc(mb_cnt, 16, b_en, b_up);
    mb_cnt  = m_next(mb_cnt, 16, b_rst, b_load, int'(b_lv), b_en, b_up);
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_count", 32'(a_cnt),  ma_cnt);
      chk("a_gray",  32'(a_gray), ma_cnt ^ (ma_cnt >> 1));
      chk("a_tc",    32'(a_tc),   int'(m_tc(ma_cnt, 6, a_en, a_up)));
      chk("a_wrap",  32'(a_wrap), int'(ma_wrap));
      chk("b_count", 32'(b_cnt),  mb_cnt);
      chk("b_gray",  32'(b_gray), mb_cnt ^ (mb_cnt >> 1));
      chk("b_tc",    32'(b_tc),   int'(m_tc(mb_cnt, 16, b_en, b_up)));
      chk("b_wrap",  32'(b_wrap), int'(mb_wrap));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int e_up_c[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int e_up_t[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int e_up_w[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int e_dn_c[4] = '{1, 0, 5, 4};
  int e_dn_t[4] = '{0, 1, 0, 0};
  int e_dn_w[4] = '{0, 0, 1, 0};

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_up = 1'b0; a_load = 1'b0; a_lv = '0;
    b_rst = 1'b1; b_en = 1'b0; b_up = 1'b0; b_load = 1'b0; b_lv = '0;
    step();
    chk_on = 1'b1;
    step();
    chk("rst_count", 32'(a_cnt), 0);
    chk("rst_wrap",  32'(a_wrap), 0);
    chk("rst_tc",    32'(a_tc), 0);
    chk("rst_b_count", 32'(b_cnt), 0);

    // Count up through the wrap.
    a_rst = 1'b0; b_rst = 1'b0; a_en = 1'b1; a_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("up_count", 32'(a_cnt), e_up_c[i]);
      chk("up_tc",    32'(a_tc), e_up_t[i]);
      chk("up_wrap",  32'(a_wrap), e_up_w[i]);
    end

    // Count down from 2 through the wrap.
    a_up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dn_count", 32'(a_cnt), e_dn_c[i]);
      chk("dn_tc",    32'(a_tc), e_dn_t[i]);
      chk("dn_wrap",  32'(a_wrap), e_dn_w[i]);
    end

    // Load clamping and load priority.
    a_en = 1'b0; a_load = 1'b1; a_lv = 3'd7;
    step();
    chk("ld_clamp7", 32'(a_cnt), 5);
    chk("ld_clamp7_wrap", 32'(a_wrap), 0);
    a_lv = 3'd6;
    step();
    chk("ld_clamp6", 32'(a_cnt), 5);
    a_lv = 3'd3; a_en = 1'b1; a_up = 1'b1;
    step();
    chk("ld_wins", 32'(a_cnt), 3);
    a_lv = 3'd5;
    step();
    chk("ld_tc_pre", 32'(a_tc), 1);
    a_lv = 3'd1;
    step();
    chk("ld_at_tc_count", 32'(a_cnt), 1);
    chk("ld_at_tc_wrap",  32'(a_wrap), 0);
    a_load = 1'b0; a_en = 1'b0;
    step();
    chk("hold_after_ld", 32'(a_cnt), 1);
    chk("hold_after_ld_wrap", 32'(a_wrap), 0);

    // Reset mid-count overrides a coincident load.
    a_load = 1'b1; a_lv = 3'd3;
    step();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    step();
    chk("pre_rst_count", 32'(a_cnt), 4);
    a_rst = 1'b1; a_load = 1'b1; a_lv = 3'd2; a_up = 1'b0;
    step();
    chk("rst_ld_count", 32'(a_cnt), 0);
    chk("rst_ld_wrap",  32'(a_wrap), 0);
    chk("rst_tc_follow", 32'(a_tc), 1);
    step();
    chk("rst_tc_nowrap", 32'(a_wrap), 0);
    a_rst = 1'b0; a_load = 1'b0; a_up = 1'b1;
    step();
    chk("post_rst_count", 32'(a_cnt), 1);
    chk("post_rst_wrap",  32'(a_wrap), 0);

    // Enable low freezes the count regardless of direction toggling.
    a_load = 1'b1; a_lv = 3'd3; a_en = 1'b0;
    step();
    a_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_up = (i % 2 == 0);
      step();
      chk("freeze_count", 32'(a_cnt), 3);
      chk("freeze_tc",    32'(a_tc), 0);
      chk("freeze_wrap",  32'(a_wrap), 0);
    end

    // Full-range modulus: 14 -> 15 -> 0 with wrap, then down wrap.
    b_load = 1'b1; b_lv = 4'd14;
    step();
    chk("b_ld_count", 32'(b_cnt), 14);
    chk("b_gray_14", 32'(b_gray), 9);
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    chk("b_tc_14", 32'(b_tc), 0);
    step();
    chk("b_count_15", 32'(b_cnt), 15);
    chk("b_gray_15", 32'(b_gray), 8);
    chk("b_tc_15", 32'(b_tc), 1);
    chk("b_wrap_15", 32'(b_wrap), 0);
    step();
    chk("b_count_0", 32'(b_cnt), 0);
    chk("b_gray_0", 32'(b_gray), 0);
    chk("b_wrap_0", 32'(b_wrap), 1);
    b_up = 1'b0;
    step();
    chk("b_dn_count", 32'(b_cnt), 15);
    chk("b_dn_wrap", 32'(b_wrap), 1);
    step();
    chk("b_dn2_count", 32'(b_cnt), 14);
    chk("b_dn2_wrap", 32'(b_wrap), 0);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
